// File: rtl/led_scan_pkg.sv
// -----------------------------------------------------------------------------
// led_scan_pkg
// Shared types and helpers for the LED scan controller.
//   state_e     : scan FSM states (IDLE, DEAD, DRIVE)
//   CS_ALL_OFF  : all chip selects deasserted (active-low), sized for the
//                 widest supported bank count; users slice to NDIG bits
//   max_int     : larger of two integers
//   cnt_width   : counter width able to hold 0..n-1, never less than 1 bit
// -----------------------------------------------------------------------------
package led_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        DRIVE = 2'd2
    } state_e;

    localparam int MAX_DIG = 4;
    localparam logic [MAX_DIG-1:0] CS_ALL_OFF = '1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// -----------------------------------------------------------------------------
// led_scan_timer
// Loadable terminal counter used to time the DEAD and DRIVE phases.
//   ck_i     : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   clear_i  : force the count back to 0 on the next edge
//   last_i   : terminal count (phase length minus one)
//   done_o   : high during the final cycle of the phase; the count wraps to 0
//              on the edge that ends it, so back-to-back phases need no clear
// -----------------------------------------------------------------------------
module led_scan_timer #(
    parameter int CW = 2
) (
    input  logic          ck_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic [CW-1:0] last_i,
    output logic          done_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign done_o = (cnt_q == last_i);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || done_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge ck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// -----------------------------------------------------------------------------
// led_scan_ctrl
// Time-multiplexes one 8-bit LED bus across NDIG banks with active-low chip
// selects. Patterns are written into a shadow table and copied to the active
// table only at the end of a frame, so a bank never shows a half-updated frame.
// Every bank is preceded by an all-off dead time; banks may blink per frame pair.
//   ck          : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   enable      : 1 = scan, 0 = all banks off (returns to IDLE)
//   wr_en       : write request (valid)
//   wr_addr     : bank index for the write
//   wr_data     : pattern for bank wr_addr
//   wr_ready    : write accepted on a cycle with wr_en && wr_ready
//   blink_mask  : bit d set = bank d blinks
//   led         : shared pattern bus, active-high, registered
//   CS          : active-low one-hot bank select, registered
//   frame_done  : one-cycle pulse after the last bank of every frame
//   dbg_state   : current FSM state (state_e encoding)
//
// Write handshake: wr_en is the valid. A transfer happens on every rising edge
// where wr_en && wr_ready. wr_ready drops only for the single cycle in which
// the shadow table is committed; a requester that keeps wr_en high through that
// cycle is accepted on the following edge, so the write lands in the next frame.
// -----------------------------------------------------------------------------
module led_scan_ctrl
    import led_scan_pkg::*;
#(
    parameter int NDIG         = 3,
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD_CYC     = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic            ck,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            wr_en,
    input  logic [1:0]      wr_addr,
    input  logic [7:0]      wr_data,
    output logic            wr_ready,
    input  logic [NDIG-1:0] blink_mask,
    output logic [7:0]      led,
    output logic [NDIG-1:0] CS,
    output logic            frame_done,
    output logic [1:0]      dbg_state
);

    localparam int CW = cnt_width(max_int(SCAN_DIV, DEAD_CYC));
    localparam int BW = cnt_width(BLINK_FRAMES);
    localparam logic [CW-1:0]   DRIVE_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]   DEAD_LAST  = CW'(DEAD_CYC - 1);
    localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [1:0]      DIG_LAST   = 2'(NDIG - 1);
    localparam logic [NDIG-1:0] CS_OFF     = CS_ALL_OFF[NDIG-1:0];

    state_e          state_q;
    logic [1:0]      digit_q;
    logic [BW-1:0]   blink_cnt_q;
    logic            blink_phase_q;
    logic [7:0]      shadow_q [NDIG];
    logic [7:0]      active_q [NDIG];
    logic            dirty_q;

    logic            tmr_clear;
    logic [CW-1:0]   tmr_last;
    logic            tmr_done;
    logic            frame_end;
    logic            wr_fire;
    logic            wr_addr_ok;
    logic [7:0]      drive_led;
    logic [NDIG-1:0] drive_cs;

    // Counter is held at 0 while idle or disabled so the first DEAD phase
    // after enabling starts counting from a clean 0.
    assign tmr_clear = !enable || (state_q == IDLE);
    assign tmr_last  = (state_q == DRIVE) ? DRIVE_LAST : DEAD_LAST;

    led_scan_timer #(
        .CW (CW)
    ) u_timer (
        .ck_i    (ck),
        .rst_ni  (rst_n),
        .clear_i (tmr_clear),
        .last_i  (tmr_last),
        .done_o  (tmr_done)
    );

    // Final cycle of the last bank: this is also the table commit cycle.
    assign frame_end  = enable && (state_q == DRIVE) && (digit_q == DIG_LAST) && tmr_done;
    assign wr_ready   = !frame_end;
    assign wr_fire    = wr_en && wr_ready;
    assign wr_addr_ok = (int'(wr_addr) < NDIG);

    assign drive_led = (blink_mask[digit_q] && blink_phase_q) ? 8'h00 : active_q[digit_q];
    assign drive_cs  = ~(NDIG'(1) << digit_q);

    assign dbg_state = state_q;

    // Pattern tables. Commit and write can never coincide because wr_ready is
    // low in the commit cycle.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NDIG; i++) begin
                shadow_q[i] <= 8'h00;
                active_q[i] <= 8'h00;
            end
            dirty_q <= 1'b0;
        end else if (frame_end) begin
            if (dirty_q) begin
                for (int i = 0; i < NDIG; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            dirty_q <= 1'b0;
        end else if (wr_fire && wr_addr_ok) begin
            shadow_q[wr_addr] <= wr_data;
            dirty_q           <= 1'b1;
        end
    end

    // Scan FSM with registered led/CS/frame_done, plus frame-level blink counting.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            digit_q       <= 2'd0;
            led           <= 8'h00;
            CS            <= CS_OFF;
            frame_done    <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (!enable) begin
            state_q    <= IDLE;
            digit_q    <= 2'd0;
            led        <= 8'h00;
            CS         <= CS_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q <= DEAD;
                    led     <= 8'h00;
                    CS      <= CS_OFF;
                end
                DEAD: begin
                    if (tmr_done) begin
                        state_q <= DRIVE;
                        led     <= drive_led;
                        CS      <= drive_cs;
                    end else begin
                        led <= 8'h00;
                        CS  <= CS_OFF;
                    end
                end
                DRIVE: begin
                    if (tmr_done) begin
                        state_q <= DEAD;
                        led     <= 8'h00;
                        CS      <= CS_OFF;
                        if (digit_q == DIG_LAST) begin
                            digit_q    <= 2'd0;
                            frame_done <= 1'b1;
                            if (blink_cnt_q == BLINK_LAST) begin
                                blink_cnt_q   <= '0;
                                blink_phase_q <= !blink_phase_q;
                            end else begin
                                blink_cnt_q <= blink_cnt_q + BW'(1);
                            end
                        end else begin
                            digit_q <= digit_q + 2'd1;
                        end
                    end else begin
                        // blink_mask is re-sampled every drive cycle
                        led <= drive_led;
                        CS  <= drive_cs;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    led     <= 8'h00;
                    CS      <= CS_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_scan_ctrl
// Directed bench for led_scan_ctrl with NDIG=3, SCAN_DIV=4, DEAD_CYC=1,
// BLINK_FRAMES=2. One frame is 15 cycles: dead, bank0 x4, dead, bank1 x4,
// dead, bank2 x4. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_led_scan_ctrl;

    logic       ck;
    logic       rst_n;
    logic       enable;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [2:0] blink_mask;
    logic [7:0] led;
    logic [2:0] CS;
    logic       frame_done;
    logic [1:0] dbg_state;

    int n_tot = 0;
    int n_bad = 0;

    logic [7:0] sh  [3];
    logic [7:0] act [3];

    led_scan_ctrl #(
        .NDIG         (3),
        .SCAN_DIV     (4),
        .DEAD_CYC     (1),
        .BLINK_FRAMES (2)
    ) dut (
        .ck         (ck),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .blink_mask (blink_mask),
        .led        (led),
        .CS         (CS),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected CS at cycle p (0..14) of a frame.
    function automatic logic [2:0] exp_cs(input int p);
        if (p >= 1 && p <= 4)   return 3'b110;
        if (p >= 6 && p <= 9)   return 3'b101;
        if (p >= 11 && p <= 14) return 3'b011;
        return 3'b111;
    endfunction

    // Bank driven at frame cycle p, or -1 during dead time.
    function automatic int bank_of(input int p);
        if (p == 0 || p == 5 || p == 10) return -1;
        return (p - 1) / 5;
    endfunction

    // Expected led: bank 2 blinks (mask 100), phase flips every 2 frames.
    function automatic logic [7:0] exp_led(input int p, input int fi);
        int b;
        b = bank_of(p);
        if (b < 0) return 8'h00;
        if (b == 2 && ((fi / 2) % 2) == 1) return 8'h00;
        return act[b];
    endfunction

    task automatic write_now(input logic [1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    initial begin
        int p;
        int fi;
        rst_n      = 1'b0;
        enable     = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = 2'd0;
        wr_data    = 8'h00;
        blink_mask = 3'b100;
        for (int i = 0; i < 3; i++) begin
            sh[i]  = 8'h00;
            act[i] = 8'h00;
        end

        // reset state
        @(negedge ck);
        chk("rst_cs", CS, 3'b111);
        chk("rst_led", led, 8'h00);
        chk("rst_fdone", frame_done, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_state", dbg_state, 2'd0);
        rst_n = 1'b1;

        // preload shadow table while idle
        @(negedge ck); write_now(2'd0, 8'h11); sh[0] = 8'h11;
        @(negedge ck); write_now(2'd1, 8'h22); sh[1] = 8'h22;
        @(negedge ck); write_now(2'd2, 8'hFF); sh[2] = 8'hFF;
        @(negedge ck); wr_en = 1'b0;
        chk("idle_cs", CS, 3'b111);
        chk("idle_led", led, 8'h00);
        enable = 1'b1;

        // k = number of edges since enable was sampled
        for (int k = 0; k < 128; k++) begin
            @(negedge ck);
            p  = k % 15;
            fi = k / 15;
            if (k > 0 && p == 0) begin
                for (int i = 0; i < 3; i++) act[i] = sh[i];
            end
            if (k == 18) sh[1] = 8'hA5;
            if (k == 46) sh[0] = 8'h5A;
            chk($sformatf("cs k=%0d", k), CS, exp_cs(p));
            chk($sformatf("led k=%0d", k), led, exp_led(p, fi));
            chk($sformatf("fdone k=%0d", k), frame_done, (k > 0 && p == 0));
            chk($sformatf("wr_ready k=%0d", k), wr_ready, (p != 14));
            case (k)
                17:      write_now(2'd1, 8'hA5);   // mid-frame write
                18:      wr_en = 1'b0;
                44:      write_now(2'd0, 8'h5A);   // held across commit
                46:      wr_en = 1'b0;
                127:     enable = 1'b0;            // during DRIVE(1)
                default: ;
            endcase
        end

        // disable mid-drive
        @(negedge ck);
        chk("dis_cs", CS, 3'b111);
        chk("dis_led", led, 8'h00);
        chk("dis_fdone", frame_done, 1'b0);
        chk("dis_state", dbg_state, 2'd0);
        @(negedge ck);
        chk("dis_cs2", CS, 3'b111);
        enable = 1'b1;

        // re-enable restarts at dead then bank0; blink phase retained (shown)
        for (int j = 0; j < 13; j++) begin
            @(negedge ck);
            chk($sformatf("ren_cs j=%0d", j), CS, exp_cs(j));
            chk($sformatf("ren_led j=%0d", j), led, exp_led(j, 0));
            chk($sformatf("ren_fdone j=%0d", j), frame_done, 1'b0);
            if (j == 0) chk("ren_state", dbg_state, 2'd1);
        end

        // async reset between edges during DRIVE(2)
        @(negedge ck);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs", CS, 3'b111);
        chk("arst_led", led, 8'h00);
        chk("arst_state", dbg_state, 2'd0);
        enable = 1'b0;
        @(negedge ck);
        rst_n = 1'b1;
        write_now(2'd3, 8'h77);
        #1;
        chk("bad_addr_ready", wr_ready, 1'b1);
        @(negedge ck);
        wr_en  = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge ck);
            p = k % 15;
            chk($sformatf("post_cs k=%0d", k), CS, exp_cs(p));
            chk($sformatf("post_led k=%0d", k), led, 8'h00);
            chk($sformatf("post_fdone k=%0d", k), frame_done, (k > 0 && p == 0));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
